// File: rtl/fpu_pkg.sv
// Shared types and encodings for the FPU issue queue.
// Request payload struct, op codes and flag bit positions.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_NAN  = 1;
    localparam int FLG_ZERO = 0;

    typedef struct packed {
        logic [31:0] opd1;
        logic [31:0] opd2;
        logic [1:0]  op;
    } fpu_req_t;

    function automatic logic [3:0] pack_flags(
        input logic ovf,
        input logic unf,
        input logic nan,
        input logic zero
    );
        logic [3:0] f;
        f           = '0;
        f[FLG_OVF]  = ovf;
        f[FLG_UNF]  = unf;
        f[FLG_NAN]  = nan;
        f[FLG_ZERO] = zero;
        return f;
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
// Head data reads as zero while empty.
module fpu_req_fifo #(
    parameter int W     = 66,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_wdata,
    output logic [W-1:0]               o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push & ~i_flush)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push & ~w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop & ~w_push)
                r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/fpu_issue_queue.sv
// Request FIFO, registered response slot and sticky flags
// wrapped around a combinational fpu datapath.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_opd1,
    input  logic [31:0]            req_opd2,
    input  logic [1:0]             req_op,
    input  logic [TAG_W-1:0]       req_tag,
    output logic [31:0]            fpu_opd1,
    output logic [31:0]            fpu_opd2,
    output logic [1:0]             fpu_op,
    input  logic [31:0]            fpu_res,
    input  logic                   fpu_ovf,
    input  logic                   fpu_unf,
    input  logic                   fpu_nan,
    input  logic                   fpu_zero,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_res,
    output logic [3:0]             rsp_flags,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic [3:0]             sticky_flags,
    input  logic                   sticky_clr,
    output logic [$clog2(DEPTH):0] count
);
    localparam int W = $bits(fpu_req_t) + TAG_W;

    fpu_req_t         w_req_in;
    fpu_req_t         w_head;
    logic [TAG_W-1:0] w_head_tag;
    logic [W-1:0]     w_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_cap;
    logic [3:0]       w_new_flags;

    logic             r_rsp_valid;
    logic [31:0]      r_rsp_res;
    logic [3:0]       r_rsp_flags;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [3:0]       r_sticky;

    assign w_req_in = '{opd1: req_opd1, opd2: req_opd2, op: req_op};
    assign {w_head_tag, w_head} = w_rdata;

    assign req_ready = ~w_full;
    assign w_push    = req_valid & req_ready;
    assign w_cap     = ~w_empty & (~r_rsp_valid | rsp_ready);

    assign w_new_flags = pack_flags(fpu_ovf, fpu_unf, fpu_nan, fpu_zero);

    fpu_req_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_push),
        .i_pop   (w_cap),
        .i_wdata ({req_tag, w_req_in}),
        .o_rdata (w_rdata),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign fpu_opd1 = w_head.opd1;
    assign fpu_opd2 = w_head.opd2;
    assign fpu_op   = w_head.op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_flags <= '0;
            r_rsp_tag   <= '0;
        end else if (flush) begin
            r_rsp_valid <= 1'b0;
        end else if (w_cap) begin
            r_rsp_valid <= 1'b1;
            r_rsp_res   <= fpu_res;
            r_rsp_flags <= w_new_flags;
            r_rsp_tag   <= w_head_tag;
        end else if (r_rsp_valid & rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Clear wins over history but not over flags captured this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sticky <= '0;
        else
            r_sticky <= (sticky_clr ? 4'b0 : r_sticky)
                      | ((w_cap & ~flush) ? w_new_flags : 4'b0);
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_res      = r_rsp_res;
    assign rsp_flags    = r_rsp_flags;
    assign rsp_tag      = r_rsp_tag;
    assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue with a table-driven fpu stub.
// Checks latency, ordering, backpressure, sticky flags, flush, reset.
module tb_fpu_issue_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_opd1 = '0;
    logic [31:0]       req_opd2 = '0;
    logic [1:0]        req_op = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [31:0]       fpu_opd1;
    logic [31:0]       fpu_opd2;
    logic [1:0]        fpu_op;
    logic [31:0]       fpu_res;
    logic              fpu_ovf;
    logic              fpu_unf;
    logic              fpu_nan;
    logic              fpu_zero;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_res;
    logic [3:0]        rsp_flags;
    logic [TAG_W-1:0]  rsp_tag;
    logic [3:0]        sticky_flags;
    logic              sticky_clr = 1'b0;
    logic [$clog2(DEPTH):0] count;

    logic stub_ovf = 1'b0;
    logic stub_nan = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_issue_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opd1     (req_opd1),
        .req_opd2     (req_opd2),
        .req_op       (req_op),
        .req_tag      (req_tag),
        .fpu_opd1     (fpu_opd1),
        .fpu_opd2     (fpu_opd2),
        .fpu_op       (fpu_op),
        .fpu_res      (fpu_res),
        .fpu_ovf      (fpu_ovf),
        .fpu_unf      (fpu_unf),
        .fpu_nan      (fpu_nan),
        .fpu_zero     (fpu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_res      (rsp_res),
        .rsp_flags    (rsp_flags),
        .rsp_tag      (rsp_tag),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .count        (count)
    );

    // Known IEEE vectors from a table; anything else is an integer sum.
    always_comb begin
        fpu_res = fpu_opd1 + fpu_opd2;
        if (fpu_op == OP_ADD && fpu_opd1 == 32'h3F800000
            && fpu_opd2 == 32'h40000000)
            fpu_res = 32'h40400000;
        else if (fpu_op == OP_MUL && fpu_opd1 == 32'h40000000
                 && fpu_opd2 == 32'h40400000)
            fpu_res = 32'h40C00000;
        else if (fpu_op == OP_DIV && fpu_opd1 == 32'h40C00000
                 && fpu_opd2 == 32'h40000000)
            fpu_res = 32'h40400000;
        fpu_ovf  = stub_ovf;
        fpu_unf  = 1'b0;
        fpu_nan  = stub_nan;
        fpu_zero = 1'b0;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [3:0] tag);
        req_valid = 1'b1;
        req_opd1  = a;
        req_opd2  = b;
        req_op    = op;
        req_tag   = tag;
    endtask

    initial begin
        // reset
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_sticky", 64'(sticky_flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("empty_fpu_opd1", 64'(fpu_opd1), 64'd0);

        // single request
        set_req(32'h3F800000, 32'h40000000, OP_ADD, 4'd3);
        tick();
        req_valid = 1'b0;
        chk("single_count1", 64'(count), 64'd1);
        chk("single_fpu_opd1", 64'(fpu_opd1), 64'h3F800000);
        chk("single_fpu_opd2", 64'(fpu_opd2), 64'h40000000);
        chk("single_rsp_early", 64'(rsp_valid), 64'd0);
        tick();
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_res", 64'(rsp_res), 64'h40400000);
        chk("single_rsp_tag", 64'(rsp_tag), 64'd3);
        chk("single_count0", 64'(count), 64'd0);
        tick();
        chk("single_drain", 64'(rsp_valid), 64'd0);

        // back-to-back
        set_req(32'h40000000, 32'h40400000, OP_MUL, 4'd1);
        tick();
        set_req(32'h40C00000, 32'h40000000, OP_DIV, 4'd2);
        tick();
        req_valid = 1'b0;
        chk("b2b_res1", 64'(rsp_res), 64'h40C00000);
        chk("b2b_tag1", 64'(rsp_tag), 64'd1);
        chk("b2b_count", 64'(count), 64'd1);
        tick();
        chk("b2b_valid2", 64'(rsp_valid), 64'd1);
        chk("b2b_res2", 64'(rsp_res), 64'h40400000);
        chk("b2b_tag2", 64'(rsp_tag), 64'd2);
        tick();
        chk("b2b_drain", 64'(rsp_valid), 64'd0);

        // backpressure
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(32'h10 + 32'(i), 32'h0, OP_ADD, 4'(i));
            tick();
        end
        chk("bp_count_full", 64'(count), 64'd4);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_hold_tag", 64'(rsp_tag), 64'd0);
        chk("bp_hold_res", 64'(rsp_res), 64'h10);
        set_req(32'h77, 32'h0, OP_ADD, 4'd7);
        tick();
        chk("bp_no_push", 64'(count), 64'd4);
        chk("bp_stable_tag", 64'(rsp_tag), 64'd0);
        chk("bp_stable_res", 64'(rsp_res), 64'h10);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            tick();
            chk("bp_order_tag", 64'(rsp_tag), 64'(j));
            chk("bp_order_res", 64'(rsp_res), 64'h10 + 64'(j));
            chk("bp_count_drain", 64'(count), 64'(4 - j));
        end
        tick();
        chk("bp_empty_valid", 64'(rsp_valid), 64'd0);

        // sticky flags
        stub_nan = 1'b1;
        set_req(32'h1, 32'h2, OP_ADD, 4'd5);
        tick();
        req_valid = 1'b0;
        tick();
        chk("stk_rsp_flags", 64'(rsp_flags), 64'b0010);
        chk("stk_sticky", 64'(sticky_flags), 64'b0010);
        stub_nan = 1'b0;
        set_req(32'h3, 32'h4, OP_SUB, 4'd6);
        tick();
        req_valid  = 1'b0;
        sticky_clr = 1'b1;
        stub_ovf   = 1'b1;
        tick();
        sticky_clr = 1'b0;
        stub_ovf   = 1'b0;
        chk("stk_clr_cap", 64'(sticky_flags), 64'b1000);
        chk("stk_ovf_flags", 64'(rsp_flags), 64'b1000);
        tick();

        // flush
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(32'h20 + 32'(i), 32'h0, OP_ADD, 4'(8 + i));
            tick();
        end
        chk("fl_pre_count", 64'(count), 64'd3);
        chk("fl_pre_valid", 64'(rsp_valid), 64'd1);
        set_req(32'h99, 32'h0, OP_ADD, 4'd15);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        stub_nan  = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        stub_nan  = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'(rsp_valid), 64'd0);
        chk("fl_sticky", 64'(sticky_flags), 64'b1000);
        tick();
        chk("fl_dropped", 64'(count), 64'd0);
        chk("fl_no_rsp", 64'(rsp_valid), 64'd0);

        // async reset
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(32'h30 + 32'(i), 32'h0, OP_ADD, 4'(i + 1));
            tick();
        end
        req_valid = 1'b0;
        chk("ar_full", 64'(count), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_valid", 64'(rsp_valid), 64'd0);
        chk("ar_res", 64'(rsp_res), 64'd0);
        chk("ar_tag", 64'(rsp_tag), 64'd0);
        chk("ar_flags", 64'(rsp_flags), 64'd0);
        chk("ar_sticky", 64'(sticky_flags), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("ar_ready", 64'(req_ready), 64'd1);
        set_req(32'h3F800000, 32'h40000000, OP_ADD, 4'd9);
        tick();
        req_valid = 1'b0;
        tick();
        chk("ar_new_valid", 64'(rsp_valid), 64'd1);
        chk("ar_new_res", 64'(rsp_res), 64'h40400000);
        chk("ar_new_tag", 64'(rsp_tag), 64'd9);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_queue.md
Name: fpu_issue_queue

Overview:
Sequential front/back end wrapped around the combinational fpu datapath.
- Accepts tagged operation requests over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents the FIFO head to the fpu, captures its result and flags into a registered response slot, and returns it over a valid/ready handshake.
- Accumulates sticky exception flags for software readback.

Parameters:
DEPTH, 4, request FIFO entries; power of two, >= 2
TAG_W, 4, width of the request tag echoed on the response

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; drops all queued requests and the pending response
req_valid  in  1  request present
req_ready  out  1  queue can accept
req_opd1  in  32  IEEE-754 single operand 1
req_opd2  in  32  IEEE-754 single operand 2
req_op  in  2  00 add, 01 sub, 10 mul, 11 div
req_tag  in  TAG_W  request tag
fpu_opd1  out  32  to fpu opd1
fpu_opd2  out  32  to fpu opd2
fpu_op  out  2  to fpu op
fpu_res  in  32  from fpu res
fpu_ovf  in  1  from fpu exp_overflow
fpu_unf  in  1  from fpu exp_underflow
fpu_nan  in  1  from fpu nan
fpu_zero  in  1  from fpu zero
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_res  out  32  registered result
rsp_flags  out  4  {ovf,unf,nan,zero} for this result
rsp_tag  out  TAG_W  tag of this result
sticky_flags  out  4  OR of rsp_flags since last clear, same bit order
sticky_clr  in  1  clears sticky_flags
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, async): count=0, rd/wr pointers=0, rsp_valid=0, rsp_res=0, rsp_flags=0, rsp_tag=0, sticky_flags=0. req_ready=1 once reset is released.
- req_ready = (count < DEPTH). There is no combinational ready-through when full.
- Push: req_valid & req_ready writes {opd1,opd2,op,tag} at wr_ptr. wr_ptr wraps modulo DEPTH.
- FIFO head drives fpu_opd1/opd2/op combinationally. When the FIFO is empty these outputs are 0 (op=00).
- Capture: cap = (count != 0) & (~rsp_valid | rsp_ready). On cap:
  - rsp_res<=fpu_res, rsp_flags<={fpu_ovf,fpu_unf,fpu_nan,fpu_zero}, rsp_tag<=head tag, rsp_valid<=1.
  - rd_ptr advances, modulo DEPTH.
- rsp_valid & rsp_ready & ~cap -> rsp_valid<=0.
- A held response (rsp_valid & ~rsp_ready) keeps rsp_res/flags/tag stable. The head is not consumed.
- Latency: request accepted at edge k into an empty queue with a free slot gives rsp_valid=1 after edge k+1. Sustained throughput is 1 result/cycle when rsp_ready=1.
- Count update:
  - push only: +1
  - cap only: -1
  - push & cap: unchanged
  - push & cap when count==DEPTH cannot occur, because req_ready=0.
- Simultaneous push and cap on an empty FIFO is impossible (cap needs count != 0). A request always spends at least one cycle in the FIFO.
- Responses emerge in request order. Tags are echoed and never interpreted.
- sticky_flags: next = (sticky_clr ? 0 : sticky_flags) | (cap ? new_flags : 0). Flags captured in the clear cycle survive.
- flush (sync):
  - count, pointers and rsp_valid go to 0.
  - A push or cap in the same cycle is discarded.
  - sticky_flags is not affected by flush; a cap suppressed by flush contributes no flags.
  - flush has priority over all other updates except rst_n.
- Reset asserted mid-operation discards everything immediately; there are no partial responses.

Decomposition:
- Shared package fpu_pkg:
  - op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - flag bit indices FLG_OVF=3, FLG_UNF=2, FLG_NAN=1, FLG_ZERO=0
  - packed request struct {opd1, opd2, op}; tag stays parameterised outside the struct
- One sub-module: fpu_req_fifo, a generic sync FIFO with parameterised width/depth, push/pop/flush and count. The top handles the response slot, capture logic and sticky flags.

Test Plan:
- Single request opd1=0x3F800000, opd2=0x40000000, op=00, tag=3, rsp_ready=1 -> fpu_* driven at edge k+1; rsp_valid after edge k+1, rsp_res=0x40400000, rsp_tag=3; count returns to 0.
- Back-to-back: mul 0x40000000*0x40400000 (tag 1), then div 0x40C00000/0x40000000 (tag 2), rsp_ready=1 -> consecutive responses 0x40C00000 tag1, 0x40400000 tag2 on consecutive cycles.
- Backpressure: rsp_ready=0, push DEPTH+1=5 requests -> 1 captured into the slot; then count reaches 4 with req_ready=0 until rsp_ready rises; all 5 responses arrive in order, stable while held.
- Sticky: stub fpu_nan=1 on one capture -> rsp_flags=0010, sticky=0010; sticky_clr in the same cycle as a capture with fpu_ovf=1 -> sticky=1000.
- Flush with count=3 and rsp_valid=1, plus req_valid in the same cycle -> count=0, rsp_valid=0, pushed request dropped, sticky unchanged.
- Async reset: drop rst_n between clock edges with the queue full -> all outputs go to reset values immediately; after release req_ready=1 and the first new request completes normally.
